// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding, image size helper, checksum width.
// Pure declarations; no logic, no latency, no flow control.
package program_loader_pkg;

  localparam int unsigned DEFAULT_ADDR_WIDTH = 10;
  localparam int unsigned CSUM_WIDTH         = 8;

  function automatic int unsigned max_words(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

  localparam int unsigned MAX_WORDS = max_words(DEFAULT_ADDR_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_COUNT_HI = 3'd1,
    S_COUNT_LO = 3'd2,
    S_DATA_HI  = 3'd3,
    S_DATA_LO  = 3'd4,
    S_CHECK    = 3'd5,
    S_DONE     = 3'd6,
    S_ERROR    = 3'd7
  } state_t;

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and program-RAM write port of the loader, bundled for port connection.
// Wiring only; no latency. No backpressure: rx_valid is a strobe, mem_write_enable a one-cycle pulse.
interface program_loader_if
  import program_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) ();

  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [15:0]           mem_data_out;
  logic                  mem_write_enable;

  modport master (
    input  rx_data, rx_valid,
    output mem_address, mem_data_out, mem_write_enable
  );

  modport slave (
    output rx_data, rx_valid,
    input  mem_address, mem_data_out, mem_write_enable
  );

endinterface

// File: rtl/program_loader_byte_timeout.sv
// Inter-byte watchdog: down-counter reloaded by clear, counting while en, expired when it hits zero.
// Latency: expired asserts LOAD_VALUE+1 enabled cycles after the cycle clear was high; no backpressure.
module program_loader_byte_timeout #(
  parameter int unsigned       WIDTH      = 24,
  parameter logic [WIDTH-1:0]  LOAD_VALUE = '1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic expired
);

  logic [WIDTH-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= LOAD_VALUE;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - WIDTH'(1);
    end
  end

  assign expired = en && (cnt == '0);

endmodule

// File: rtl/program_loader.sv
// Loads a big-endian byte-stream program image into 16-bit program RAM and holds the core in reset meanwhile.
// Latency: write strobe one cycle after the low byte's rx_valid. Optional trailing checksum: PROGRAM_LOADER_CHECKSUM_EN.
// Backpressure: none; every rx_valid byte is consumed, and a gap of TIMEOUT_CYCLES between bytes aborts the load.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd12_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  program_loader_if.master bus,
  output logic             cpu_reset,
  output logic             busy,
  output logic             done,
  output logic             error
);

  localparam int unsigned IW   = ADDR_WIDTH + 1;
  localparam int unsigned MAXW = max_words(ADDR_WIDTH);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  state_t        state;
  logic [7:0]    count_hi;
  logic [7:0]    data_hi;
  logic [IW-1:0] count_q;
  logic [IW-1:0] idx;
  logic [IW-1:0] idx_inc;
  logic [15:0]   count_in;
  logic          start_ok;
  logic          tmr_clr;
  logic          expired;
  logic          last_word;

  assign count_in  = {count_hi, bus.rx_data};
  assign idx_inc   = idx + IW'(1);
  assign last_word = (idx_inc == count_q);
  assign start_ok  = start && !busy;
  assign tmr_clr   = start_ok || (busy && bus.rx_valid);

  program_loader_byte_timeout #(
    .WIDTH      (24),
    .LOAD_VALUE (TIMEOUT_CYCLES - 24'd1)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (tmr_clr),
    .en      (busy),
    .expired (expired)
  );

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [CSUM_WIDTH-1:0] sum;
  logic                  csum_ok;

  assign csum_ok = (CSUM_WIDTH'(sum + bus.rx_data) == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      sum <= '0;
    end else if (start_ok) begin
      sum <= '0;
    end else if (busy && bus.rx_valid) begin
      sum <= sum + bus.rx_data;
    end
  end
`endif

  // busy is high exactly in the receive states, so it doubles as the watchdog enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      state                <= S_IDLE;
      cpu_reset            <= 1'b1;
      busy                 <= 1'b0;
      done                 <= 1'b0;
      error                <= 1'b0;
      count_hi             <= '0;
      data_hi              <= '0;
      count_q              <= '0;
      idx                  <= '0;
      bus.mem_address      <= '0;
      bus.mem_data_out     <= '0;
      bus.mem_write_enable <= 1'b0;
    end else begin
      bus.mem_write_enable <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state     <= S_COUNT_HI;
            cpu_reset <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
            idx       <= '0;
          end
        end
        S_COUNT_HI: begin
          if (bus.rx_valid) begin
            count_hi <= bus.rx_data;
            state    <= S_COUNT_LO;
          end else if (expired) begin
            state <= S_ERROR;
            busy  <= 1'b0;
            error <= 1'b1;
          end
        end
        S_COUNT_LO: begin
          if (bus.rx_valid) begin
            if (32'(count_in) > MAXW) begin
              state <= S_ERROR;
              busy  <= 1'b0;
              error <= 1'b1;
            end else if (count_in == '0) begin
              if (CSUM_EN) begin
                state <= S_CHECK;
              end else begin
                state     <= S_DONE;
                busy      <= 1'b0;
                cpu_reset <= 1'b0;
                done      <= 1'b1;
              end
            end else begin
              count_q <= IW'(count_in);
              state   <= S_DATA_HI;
            end
          end else if (expired) begin
            state <= S_ERROR;
            busy  <= 1'b0;
            error <= 1'b1;
          end
        end
        S_DATA_HI: begin
          if (bus.rx_valid) begin
            data_hi <= bus.rx_data;
            state   <= S_DATA_LO;
          end else if (expired) begin
            state <= S_ERROR;
            busy  <= 1'b0;
            error <= 1'b1;
          end
        end
        S_DATA_LO: begin
          if (bus.rx_valid) begin
            bus.mem_address      <= idx[ADDR_WIDTH-1:0];
            bus.mem_data_out     <= {data_hi, bus.rx_data};
            bus.mem_write_enable <= 1'b1;
            idx                  <= idx_inc;
            if (!last_word) begin
              state <= S_DATA_HI;
            end else if (CSUM_EN) begin
              state <= S_CHECK;
            end else begin
              state     <= S_DONE;
              busy      <= 1'b0;
              cpu_reset <= 1'b0;
              done      <= 1'b1;
            end
          end else if (expired) begin
            state <= S_ERROR;
            busy  <= 1'b0;
            error <= 1'b1;
          end
        end
        S_CHECK: begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          if (bus.rx_valid) begin
            if (csum_ok) begin
              state     <= S_DONE;
              busy      <= 1'b0;
              cpu_reset <= 1'b0;
              done      <= 1'b1;
            end else begin
              state <= S_ERROR;
              busy  <= 1'b0;
              error <= 1'b1;
            end
          end else if (expired) begin
            state <= S_ERROR;
            busy  <= 1'b0;
            error <= 1'b1;
          end
`else
          state     <= S_IDLE;
          busy      <= 1'b0;
          cpu_reset <= 1'b1;
`endif
        end
        default: begin
          state     <= S_IDLE;
          busy      <= 1'b0;
          cpu_reset <= 1'b1;
        end
      endcase
    end
  end

endmodule
